// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: blanking constants,
// the active-low hex pattern table and the digit index type.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low g..a patterns; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_PAT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h18, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment (g..a) pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] pat_o
);

    // Plain table lookup; kept as its own block so other displays can reuse it.
    always_comb begin
        pat_o = HEX_PAT[nib_i];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display.
// One anode is driven at a time; a new image is loaded through a
// valid/ready port and only becomes active at a frame boundary.
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_en,
    input  logic [7:0]  load_dp,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q;
    digit_idx_t       idx_q;
    logic             alive_q;

    logic [31:0] pend_data_q;
    logic [7:0]  pend_en_q;
    logic [7:0]  pend_dp_q;
    logic        pend_full_q;

    logic [31:0] act_data_q;
    logic [7:0]  act_en_q;
    logic [7:0]  act_dp_q;

    logic [7:0]  seg_q, seg_d;
    logic [7:0]  an_q, an_d;
    logic        tick_q;

    logic        boundary;
    logic        xfer;
    logic [3:0]  cur_nib;
    logic [6:0]  cur_pat;
    logic        lz_blank;

    assign boundary   = (div_q == DIV_LAST) && (idx_q == 3'd7);
    // alive_q holds ready low while reset is asserted and until the first clock after release.
    assign load_ready = alive_q && !pend_full_q;
    assign xfer       = load_valid && load_ready;
    assign cur_nib    = act_data_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib_i (cur_nib),
        .pat_o (cur_pat)
    );

    // Slot divider and digit index; idx advances when the divider wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            idx_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // Pending image capture and commit to the active set at the frame boundary.
    // A capture in the boundary cycle itself waits for the following boundary
    // because pend_full_q is still 0 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_q <= '0;
            pend_en_q   <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            act_data_q  <= '0;
            act_en_q    <= '0;
            act_dp_q    <= '0;
        end else begin
            if (xfer) begin
                pend_data_q <= load_data;
                pend_en_q   <= load_en;
                pend_dp_q   <= load_dp;
                pend_full_q <= 1'b1;
            end else if (boundary && pend_full_q) begin
                act_data_q  <= pend_data_q;
                act_en_q    <= pend_en_q;
                act_dp_q    <= pend_dp_q;
                pend_full_q <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    digit_idx_t lz_top;

    // Highest enabled digit with a nonzero nibble; digits above it are blank unless their dp is lit.
    always_comb begin
        lz_top = '0;
        for (int k = 1; k < 8; k++) begin
            if (act_en_q[k] && (act_data_q[4*k +: 4] != 4'h0)) begin
                lz_top = digit_idx_t'(k);
            end
        end
        lz_blank = (idx_q > lz_top) && !act_dp_q[idx_q];
    end
`else
    // Without leading-zero blanking only the per-digit enable blanks a digit.
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    // Next segment/anode values for the current slot, with an anode dead cycle at slot start.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (act_en_q[idx_q] && !lz_blank) begin
            seg_d = {~act_dp_q[idx_q], cur_pat};
            if (div_q != '0) begin
                an_d = ~(8'b1 << idx_q);
            end
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
            tick_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= boundary;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4 (32-cycle frames).
// Expectations for leading-zero blanking follow SEG7_LZ_BLANK_EN.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_en;
    logic [7:0]  load_dp;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    localparam logic [63:0] AN_ALL = 64'h7FBFDFEFF7FBFDFE;
    localparam logic [63:0] ALL_FF = 64'hFFFFFFFFFFFFFFFF;

    seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_en    (load_en),
        .load_dp    (load_dp),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_valid && load_ready) xfer_cnt <= xfer_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        @(negedge clk);
        chk("ready_before_load", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        load_en    = e;
        load_dp    = p;
        @(negedge clk);
        load_valid = 1'b0;
        chk("ready_after_load", {31'd0, load_ready}, 32'd0);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        chk("tick_wait", {31'd0, frame_tick}, 32'd1);
    endtask

    // Called at a negedge showing frame_tick; checks the following 32 cycles.
    task automatic check_frame(input logic [63:0] e_an, input logic [63:0] e_seg);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                chk($sformatf("an_d%0d_c%0d", k, j), {24'd0, an},
                    (j == 0) ? 32'h000000FF : {24'd0, e_an[8*k +: 8]});
                chk($sformatf("seg_d%0d_c%0d", k, j), {24'd0, seg}, {24'd0, e_seg[8*k +: 8]});
                chk($sformatf("tick_d%0d_c%0d", k, j), {31'd0, frame_tick},
                    (k == 7 && j == 3) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        int c0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_en    = '0;
        load_dp    = '0;

        // Reset state
        @(negedge clk);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, load_ready}, 32'd1);
        chk("rel_an", {24'd0, an}, 32'hFF);

        // Basic scan
        do_load(32'h76543210, 8'hFF, 8'h00);
        wait_tick();
        chk("ready_after_commit", {31'd0, load_ready}, 32'd1);
        check_frame(AN_ALL, 64'hF8829299B0A4F9C0);

        // Tear-free update
        do_load(32'h11111111, 8'hFF, 8'h00);
        wait_tick();
        fork
            check_frame(AN_ALL, {8{8'hF9}});
            begin
                repeat (8) @(negedge clk);
                do_load(32'h22222222, 8'hFF, 8'h00);
                repeat (10) @(negedge clk);
                chk("ready_pending", {31'd0, load_ready}, 32'd0);
            end
        join
        chk("ready_after_commit2", {31'd0, load_ready}, 32'd1);

        // Back-pressure: new image offered every cycle for two frames
        c0 = xfer_cnt;
        fork
            begin
                check_frame(AN_ALL, {8{8'hA4}});
                check_frame(AN_ALL, {8{8'hB0}});
                check_frame(AN_ALL, {8{8'h92}});
            end
            begin
                for (int i = 0; i < 64; i++) begin
                    load_valid = 1'b1;
                    load_data  = {8{4'(i % 15 + 3)}};
                    load_en    = 8'hFF;
                    load_dp    = 8'h00;
                    @(negedge clk);
                end
                load_valid = 1'b0;
                chk("bp_xfers", xfer_cnt - c0, 32'd2);
            end
        join

        // Blanking and decimal point
        do_load(32'h0000ABCD, 8'h0F, 8'h01);
        wait_tick();
        check_frame(64'hFFFFFFFFF7FBFDFE, 64'hFFFFFFFF8883C621);

        // Leading-zero blanking
        do_load(32'h00000050, 8'hFF, 8'h00);
        wait_tick();
`ifdef SEG7_LZ_BLANK_EN
        check_frame(64'hFFFFFFFFFFFFFDFE, 64'hFFFFFFFFFFFF92C0);
`else
        check_frame(AN_ALL, 64'hC0C0C0C0C0C092C0);
`endif

        // Reset mid-frame with an image pending
        do_load(32'h12345678, 8'hFF, 8'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", {24'd0, seg}, 32'hFF);
        chk("mid_rst_an", {24'd0, an}, 32'hFF);
        chk("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        chk("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", {31'd0, load_ready}, 32'd1);
        chk("mid_rel_an", {24'd0, an}, 32'hFF);
        wait_tick();
        check_frame(ALL_FF, ALL_FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
